// File: rtl/axim_write_responder_pkg.sv
// Shared definitions for the AXI write responder: response codes, FSM states, default widths.
package axim_write_responder_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

  function automatic logic [1:0] b_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axim_write_responder_if.sv
// AXI write channels (AW/W/B) plus the single-word memory write port seen by the responder.
interface axim_write_responder_if
  import axim_write_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              axi_awvalid_in;
  logic              axi_awready_out;
  logic [LEN_W-1:0]  axi_awlen_in;
  logic [ADDR_W-1:0] axi_awaddr_in;
  logic              axi_wvalid_in;
  logic              axi_wready_out;
  logic [DATA_W-1:0] axi_wdata_in;
  logic              axi_wlast_in;
  logic              axi_bvalid_out;
  logic              axi_bready_in;
  logic [1:0]        axi_bresp_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic              mem_busy_in;

  modport slave (
    input  axi_awvalid_in, axi_awlen_in, axi_awaddr_in,
    input  axi_wvalid_in, axi_wdata_in, axi_wlast_in,
    input  axi_bready_in, mem_busy_in,
    output axi_awready_out, axi_wready_out, axi_bvalid_out, axi_bresp_out,
    output mem_we_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output axi_awvalid_in, axi_awlen_in, axi_awaddr_in,
    output axi_wvalid_in, axi_wdata_in, axi_wlast_in,
    output axi_bready_in, mem_busy_in,
    input  axi_awready_out, axi_wready_out, axi_bvalid_out, axi_bresp_out,
    input  mem_we_out, mem_addr_out, mem_wdata_out
  );

endinterface

// File: rtl/axim_write_responder.sv
// AXI INCR write responder: one burst at a time, each W beat becomes a memory write one cycle later.
// W is throttled by mem_busy_in through wready; B is held stable until bready.
module axim_write_responder
  import axim_write_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  axim_write_responder_if.slave   axi
);

  wr_state_t         state_q, state_d;
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              wready;
  logic              w_fire;
  logic              last_beat;

  assign wready = (state_q == ST_DATA) && !axi.mem_busy_in;

  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    err_d       = err_q;
    cur_addr_d  = cur_addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    w_fire      = axi.axi_wvalid_in && wready;
    last_beat   = (beat_cnt_q == len_q);

    case (state_q)
      ST_IDLE: begin
        awready_d = 1'b1;
        if (axi.axi_awvalid_in && awready_q) begin
          cur_addr_d = axi.axi_awaddr_in;
          len_d      = axi.axi_awlen_in;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          awready_d  = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_fire) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr_q;
          mem_wdata_d = axi.axi_wdata_in;
          cur_addr_d  = cur_addr_q + 1'b1;
          // The beat count alone ends the burst; wlast only feeds the error flag.
          if (last_beat) begin
            err_d    = err_q | !axi.axi_wlast_in;
            bvalid_d = 1'b1;
            bresp_d  = b_resp(err_d);
            state_d  = ST_RESP;
          end else begin
            err_d      = err_q | axi.axi_wlast_in;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (axi.axi_bready_in) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign axi.axi_awready_out = awready_q;
  assign axi.axi_wready_out  = wready;
  assign axi.axi_bvalid_out  = bvalid_q;
  assign axi.axi_bresp_out   = bresp_q;
  assign axi.mem_we_out      = mem_we_q;
  assign axi.mem_addr_out    = mem_addr_q;
  assign axi.mem_wdata_out   = mem_wdata_q;

endmodule

// File: tb/tb_axim_write_responder.sv
// Scoreboard bench for axim_write_responder: expected writes/responses queued at stimulus time.
module tb_axim_write_responder;
  import axim_write_responder_pkg::*;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int LW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  wr_t        exp_wr[$];
  logic [1:0] exp_b[$];

  always #5 clk = ~clk;

  axim_write_responder_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  axim_write_responder #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .axi     (bus)
  );

  // Memory-side monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (bus.mem_we_out === 1'b1) begin
      vec_cnt++;
      if (exp_wr.size() == 0) begin
        err_cnt++;
        $display("FAIL mem_write_unexpected got addr=%h data=%h, required no write",
                 bus.mem_addr_out, bus.mem_wdata_out);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        if (bus.mem_addr_out !== e.addr || bus.mem_wdata_out !== e.data) begin
          err_cnt++;
          $display("FAIL mem_write got addr=%h data=%h, required addr=%h data=%h",
                   bus.mem_addr_out, bus.mem_wdata_out, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] lastbit(input int n);
    logic [255:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  task automatic send_burst(input string name, input logic [AW-1:0] addr, input int len,
                            input logic [DW-1:0] data0, input logic [255:0] lastm,
                            input int busy_beat, input int busy_cyc, input int bhold,
                            input bit skip_aw, input bit pend_aw,
                            input logic [AW-1:0] paddr, input int plen);
    logic       exp_err;
    logic [1:0] exp_resp;
    int         i, t, busy_left;
    logic       busy;
    exp_err = 1'b0;
    for (int j = 0; j <= len; j++) begin
      if (j < len && lastm[j]) exp_err = 1'b1;
      if (j == len && !lastm[j]) exp_err = 1'b1;
    end
    exp_b.push_back(exp_err ? 2'b10 : 2'b00);

    if (!skip_aw) begin
      @(negedge clk);
      bus.axi_awvalid_in = 1'b1;
      bus.axi_awaddr_in  = addr;
      bus.axi_awlen_in   = LW'(len);
      t = 0;
      #1;
      while (bus.axi_awready_out !== 1'b1 && t < 1000) begin
        @(negedge clk);
        #1;
        t++;
      end
      vec_cnt++;
      if (t >= 1000) begin
        err_cnt++;
        $display("FAIL %s aw_timeout awready=%b, required 1", name, bus.axi_awready_out);
        bus.axi_awvalid_in = 1'b0;
        return;
      end
    end
    for (int j = 0; j <= len; j++) exp_wr.push_back('{addr: addr + AW'(j), data: data0 + DW'(j)});

    i = 0;
    t = 0;
    busy_left = busy_cyc;
    while (i <= len && t < 5000) begin
      @(negedge clk);
      bus.axi_awvalid_in = 1'b0;
      bus.axi_wvalid_in  = 1'b1;
      bus.axi_wdata_in   = data0 + DW'(i);
      bus.axi_wlast_in   = lastm[i];
      busy = (i == busy_beat) && (busy_left > 0);
      if (busy) busy_left--;
      bus.mem_busy_in = busy;
      #1;
      vec_cnt++;
      if (bus.axi_wready_out !== !busy) begin
        err_cnt++;
        $display("FAIL %s wready beat=%0d busy=%b got %b, required %b",
                 name, i, busy, bus.axi_wready_out, !busy);
      end
      if (!busy && bus.axi_wready_out === 1'b1) i++;
      t++;
    end
    if (t >= 5000) begin
      err_cnt++;
      $display("FAIL %s beat_timeout accepted=%0d, required %0d", name, i, len + 1);
    end

    @(negedge clk);
    bus.axi_wvalid_in = 1'b0;
    bus.axi_wlast_in  = 1'b0;
    bus.mem_busy_in   = 1'b0;
    exp_resp = exp_b.pop_front();
    vec_cnt++;
    if (bus.axi_bvalid_out !== 1'b1 || bus.mem_we_out !== 1'b1 || bus.axi_wready_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s b_timing bvalid=%b mem_we=%b wready=%b, required 1 1 0",
               name, bus.axi_bvalid_out, bus.mem_we_out, bus.axi_wready_out);
    end
    vec_cnt++;
    if (bus.axi_bresp_out !== exp_resp) begin
      err_cnt++;
      $display("FAIL %s bresp got %b, required %b", name, bus.axi_bresp_out, exp_resp);
    end
    if (pend_aw) begin
      bus.axi_awvalid_in = 1'b1;
      bus.axi_awaddr_in  = paddr;
      bus.axi_awlen_in   = LW'(plen);
    end
    for (int k = 0; k < bhold; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.axi_bvalid_out !== 1'b1 || bus.axi_bresp_out !== exp_resp || bus.axi_awready_out !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s b_hold cyc=%0d bvalid=%b bresp=%b awready=%b, required 1 %b 0",
                 name, k, bus.axi_bvalid_out, bus.axi_bresp_out, bus.axi_awready_out, exp_resp);
      end
    end
    bus.axi_bready_in = 1'b1;
    @(negedge clk);
    bus.axi_bready_in = 1'b0;
    vec_cnt++;
    if (bus.axi_bvalid_out !== 1'b0 || bus.axi_awready_out !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s b_done bvalid=%b awready=%b, required 0 1",
               name, bus.axi_bvalid_out, bus.axi_awready_out);
    end
    vec_cnt++;
    if (exp_wr.size() != 0) begin
      err_cnt++;
      $display("FAIL %s writes_missing left=%0d, required 0", name, exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic test_reset();
    bus.axi_awvalid_in = 1'b0;
    bus.axi_awlen_in   = '0;
    bus.axi_awaddr_in  = '0;
    bus.axi_wvalid_in  = 1'b0;
    bus.axi_wdata_in   = '0;
    bus.axi_wlast_in   = 1'b0;
    bus.axi_bready_in  = 1'b0;
    bus.mem_busy_in    = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus.axi_awready_out !== 1'b0 || bus.axi_bvalid_out !== 1'b0 || bus.mem_we_out !== 1'b0 ||
        bus.axi_bresp_out !== 2'b00 || bus.axi_wready_out !== 1'b0 ||
        bus.mem_addr_out !== '0 || bus.mem_wdata_out !== '0) begin
      err_cnt++;
      $display("FAIL reset_state awr=%b bv=%b we=%b br=%b wr=%b a=%h d=%h, required all 0",
               bus.axi_awready_out, bus.axi_bvalid_out, bus.mem_we_out, bus.axi_bresp_out,
               bus.axi_wready_out, bus.mem_addr_out, bus.mem_wdata_out);
    end
    reset_n = 1'b1;
    #1;
    vec_cnt++;
    if (bus.axi_awready_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release_awready got %b, required 0", bus.axi_awready_out);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.axi_awready_out !== 1'b1) begin
      err_cnt++;
      $display("FAIL awready_after_reset got %b, required 1", bus.axi_awready_out);
    end
  endtask

  task automatic test_basic();
    send_burst("basic32", 25'h0, 31, 16'd100, lastbit(31), -1, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_addr_wrap();
    send_burst("wrap", 25'h1FFFFFE, 3, 16'd500, lastbit(3), -1, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_wlast_errors();
    send_burst("early_wlast", 25'h200, 7, 16'h1000, lastbit(4) | lastbit(7), -1, 0, 0, 0, 0, '0, 0);
    send_burst("no_wlast", 25'h300, 2, 16'h2000, '0, -1, 0, 0, 0, 0, '0, 0);
    send_burst("single", 25'h310, 0, 16'h2100, lastbit(0), -1, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_mem_busy();
    send_burst("busy", 25'h400, 31, 16'h3000, lastbit(31), 9, 3, 0, 0, 0, '0, 0);
  endtask

  task automatic test_b_backpressure();
    send_burst("bhold", 25'h500, 3, 16'h4000, lastbit(3), -1, 0, 10, 0, 1, 25'h600, 1);
    send_burst("pending_aw", 25'h600, 1, 16'h5000, lastbit(1), -1, 0, 0, 1, 0, '0, 0);
  endtask

  task automatic test_reset_mid_burst();
    int i, t;
    @(negedge clk);
    bus.axi_awvalid_in = 1'b1;
    bus.axi_awaddr_in  = 25'h40;
    bus.axi_awlen_in   = 8'd31;
    t = 0;
    #1;
    while (bus.axi_awready_out !== 1'b1 && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    for (int j = 0; j < 9; j++) exp_wr.push_back('{addr: 25'h40 + AW'(j), data: 16'd900 + DW'(j)});
    i = 0;
    t = 0;
    while (i < 9 && t < 1000) begin
      @(negedge clk);
      bus.axi_awvalid_in = 1'b0;
      bus.axi_wvalid_in  = 1'b1;
      bus.axi_wdata_in   = 16'd900 + DW'(i);
      bus.axi_wlast_in   = 1'b0;
      #1;
      if (bus.axi_wready_out === 1'b1) i++;
      t++;
    end
    @(negedge clk);
    bus.axi_wdata_in = 16'd909;
    #2;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.mem_we_out !== 1'b0 || bus.axi_awready_out !== 1'b0 || bus.axi_bvalid_out !== 1'b0 ||
        bus.axi_wready_out !== 1'b0 || bus.mem_addr_out !== '0) begin
      err_cnt++;
      $display("FAIL midreset_outputs we=%b awr=%b bv=%b wr=%b a=%h, required all 0",
               bus.mem_we_out, bus.axi_awready_out, bus.axi_bvalid_out,
               bus.axi_wready_out, bus.mem_addr_out);
    end
    bus.axi_wvalid_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (bus.axi_awready_out !== 1'b1 || bus.axi_bvalid_out !== 1'b0 || exp_wr.size() != 0) begin
      err_cnt++;
      $display("FAIL midreset_recover awready=%b bvalid=%b writes_left=%0d, required 1 0 0",
               bus.axi_awready_out, bus.axi_bvalid_out, exp_wr.size());
      exp_wr.delete();
    end
    send_burst("after_reset", 25'h77, 0, 16'h55AA, lastbit(0), -1, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_wrap();
    test_wlast_errors();
    test_mem_busy();
    test_b_backpressure();
    test_reset_mid_burst();
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (exp_wr.size() != 0 || bus.axi_bvalid_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL final_idle writes_left=%0d bvalid=%b, required 0 0",
               exp_wr.size(), bus.axi_bvalid_out);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
